mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EX/MEM control signals (RegWriteM, MemWriteM, ResultSrcM) and the EX/MEM datapath values.
- Drives a req/ack data-memory bus for loads and stores, and stalls the upstream pipeline until the access completes.
- Contains the MEM/WB register. It presents RegWriteW, ResultSrcW, ALUResultW and ReadDataW to the writeback stage.

Parameters:
- DW, 32, data and address width.
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ack before aborting the access (range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- RegWriteM  in  1  register-write enable from EX/MEM
- MemWriteM  in  1  store request from EX/MEM
- ResultSrcM  in  2  result select from EX/MEM; 2'b01 = load
- ALUResultM  in  DW  memory address / ALU result
- WriteDataM  in  DW  store data
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  DW  bus address
- mem_wdata  out  DW  bus write data
- mem_rdata  in  DW  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion, single-cycle pulse
- StallM  out  1  freeze IF/ID/EX/MEM registers (combinational)
- mem_err  out  1  one-cycle pulse on timeout
- RegWriteW  out  1  MEM/WB register-write enable
- ResultSrcW  out  2  MEM/WB result select
- ALUResultW  out  DW  MEM/WB ALU result
- ReadDataW  out  DW  MEM/WB load data

Behaviour:
- Definitions:
  - access = MemWriteM | (ResultSrcM == 2'b01).
  - is_load = (ResultSrcM == 2'b01).
- Reset (reset_n low, asynchronous, effective immediately, including mid-access):
  - State goes to IDLE; timeout counter = 0.
  - Outputs: mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_err = 0.
  - MEM/WB register: RegWriteW = 0, ResultSrcW = 2'b00, ALUResultW = 0, ReadDataW = 0.
  - Captured read data = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - If access: go to BUSY. Latch mem_addr ← ALUResultM, mem_wdata ← WriteDataM, mem_we ← MemWriteM. Clear the counter.
    - Otherwise: stay in IDLE.
  - BUSY:
    - mem_req = 1; mem_addr, mem_wdata and mem_we hold their latched values.
    - If mem_ack: capture mem_rdata and go to DONE.
    - Else if counter == TIMEOUT-1: capture 0, pulse mem_err = 1 for the next cycle, go to DONE.
    - Otherwise: counter + 1.
  - DONE:
    - mem_req = 0.
    - Go to IDLE unconditionally.
- mem_req is registered:
  - Rises the cycle after IDLE detects an access.
  - Falls on the edge where mem_ack is sampled (or on timeout).
- mem_ack is ignored outside BUSY.
- StallM = access & (state != DONE).
  - Non-access instructions never stall.
  - A zero-wait memory (ack in the first BUSY cycle) gives 2 stall cycles; an access occupies MEM for 3 cycles.
- MEM/WB register, rising edge:
  - When StallM = 0:
    - RegWriteW ← RegWriteM, ResultSrcW ← ResultSrcM, ALUResultW ← ALUResultM.
    - ReadDataW ← captured data if is_load, else 0.
  - When StallM = 1, load a bubble: RegWriteW ← 0, ResultSrcW ← 0, ALUResultW ← 0, ReadDataW ← 0.
- The MEM-stage inputs are held stable by the upstream stall while state != IDLE. Values latched in IDLE are authoritative for the bus.
- Back-to-back accesses:
  - DONE → IDLE, then the next access starts one cycle later.
  - mem_req is low for at least 2 cycles between requests.

Test Plan:
- Non-access (RegWriteM = 1, ResultSrcM = 00, ALUResultM = 0x10) → StallM = 0; next edge RegWriteW = 1, ALUResultW = 0x10, ReadDataW = 0.
- Load at 0x100, mem_ack with mem_rdata = 0xDEADBEEF in the first BUSY cycle → mem_req high 1 cycle with mem_we = 0 and mem_addr = 0x100; StallM high 2 cycles; then ReadDataW = 0xDEADBEEF, ResultSrcW = 01; bubbles (RegWriteW = 0) during the stall.
- Store 0x55 to 0x200, ack after 4 wait cycles → mem_we = 1, mem_wdata = 0x55 held for 5 BUSY cycles; StallM high 6 cycles; RegWriteW = 0 after completion.
- TIMEOUT = 4, load with no ack → mem_req high exactly 4 cycles; mem_err pulses 1 cycle; ReadDataW = 0; pipeline resumes.
- reset_n driven low during BUSY → mem_req and all W outputs go to 0 immediately (asynchronously); after release, state IDLE and a new load completes normally.
- Two consecutive loads with ack in the first BUSY cycle → two distinct mem_req pulses separated by at least 2 low cycles; correct ReadDataW for each in order.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: req/ack data-memory bus between the MEM stage and memory.
//
// Signals:
//   mem_req    controller -> memory  bus request
//   mem_we     controller -> memory  write enable (1 = store, 0 = load)
//   mem_addr   controller -> memory  byte address (DW bits)
//   mem_wdata  controller -> memory  store data (DW bits)
//   mem_rdata  memory -> controller  load data, valid while mem_ack is high
//   mem_ack    memory -> controller  single-cycle completion pulse
//
// Modports: master (MEM-stage controller), slave (memory model or bus bridge).
interface mem_access_ctrl_if #(
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage memory access controller with the MEM/WB register.
//
// Turns EX/MEM loads and stores into req/ack bus transactions, holds the
// upstream pipeline with StallM until each access finishes (or times out),
// and registers the writeback-stage controls and data.
//
// Ports:
//   clk, reset_n               clock (rising edge), asynchronous active-low reset
//   RegWriteM, MemWriteM       EX/MEM controls (MemWriteM = store)
//   ResultSrcM                 EX/MEM result select, 2'b01 marks a load
//   ALUResultM, WriteDataM     address / ALU result and store data
//   bus                        memory bus (master side)
//   StallM                     combinational freeze for IF/ID/EX/MEM
//   mem_err                    one-cycle pulse after a timed-out access
//   RegWriteW, ResultSrcW,
//   ALUResultW, ReadDataW      MEM/WB register outputs
module mem_access_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               RegWriteM,
  input  logic               MemWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic [DW-1:0]      ALUResultM,
  input  logic [DW-1:0]      WriteDataM,
  mem_access_ctrl_if.master  bus,
  output logic               StallM,
  output logic               mem_err,
  output logic               RegWriteW,
  output logic [1:0]         ResultSrcW,
  output logic [DW-1:0]      ALUResultW,
  output logic [DW-1:0]      ReadDataW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  // Last counter value before the access is abandoned; TIMEOUT is 1..255.
  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  stateT         state;
  stateT         nextState;
  logic [7:0]    waitCount;
  logic          access;
  logic          isLoad;
  logic          ackSeen;
  logic          timedOut;
  logic          memReq;
  logic          memWe;
  logic [DW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          memErr;
  logic [DW-1:0] capturedData;

  assign isLoad = (ResultSrcM == 2'b01);
  assign access = MemWriteM | isLoad;

  // DONE releases the stall so the finished access leaves MEM on that edge.
  assign StallM = access & (state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // mem_ack only counts while BUSY; an ack wins over a same-cycle timeout.
  always_comb begin
    nextState = state;
    ackSeen   = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE: begin
        if (access) nextState = BUSY;
      end
      BUSY: begin
        ackSeen  = bus.mem_ack;
        timedOut = !bus.mem_ack && (waitCount == LastCount);
        if (ackSeen || timedOut) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Bus-side registers: request and address/data are latched once in IDLE and
  // held for the whole access; mem_err is a pulse that clears itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWdata     <= '0;
      memErr       <= 1'b0;
      waitCount    <= '0;
      capturedData <= '0;
    end else begin
      memErr <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            memReq    <= 1'b1;
            memWe     <= MemWriteM;
            memAddr   <= ALUResultM;
            memWdata  <= WriteDataM;
            waitCount <= '0;
          end
        end
        BUSY: begin
          if (ackSeen) begin
            memReq       <= 1'b0;
            capturedData <= bus.mem_rdata;
          end else if (timedOut) begin
            memReq       <= 1'b0;
            memErr       <= 1'b1;
            capturedData <= '0;
          end else begin
            waitCount <= waitCount + 8'd1;
          end
        end
        DONE: begin
          memReq <= 1'b0;
        end
        default: begin
          memReq <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign mem_err       = memErr;

  // MEM/WB register: a stalled MEM stage hands a bubble to writeback.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
    end else begin
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= isLoad ? capturedData : '0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: self-checking bench for mem_access_ctrl.
// Two instances: one with the default TIMEOUT, one with TIMEOUT = 4; useTo
// selects which instance receives stimulus and is observed.
module tb_mem_access_ctrl;
  localparam int DW = 32;

  typedef struct {
    string       name;
    logic        useTo;
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ackWait;
    int          expStall;
    int          expReq;
    int          expErr;
    logic [31:0] expRd;
  } vecT;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rd;
  } wbT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          useTo;
  logic          rwIn, mwIn, ackIn;
  logic [1:0]    rsIn;
  logic [DW-1:0] aluIn, wdIn, rdataIn;

  logic          mRw, mMw, tRw, tMw;
  logic [1:0]    mRs, tRs;
  logic [DW-1:0] mAlu, mWd, tAlu, tWd;

  logic          mStall, mErr, mRwW, tStall, tErr, tRwW;
  logic [1:0]    mRsW, tRsW;
  logic [DW-1:0] mAluW, mRdW, tAluW, tRdW;

  logic          sStall, sErr, sReq, sWe, sRw;
  logic [1:0]    sRs;
  logic [DW-1:0] sAddr, sWdata, sAlu, sRd;

  mem_access_ctrl_if #(.DW(DW)) busMain ();
  mem_access_ctrl_if #(.DW(DW)) busTo ();

  assign mRw  = rwIn & ~useTo;
  assign mMw  = mwIn & ~useTo;
  assign mRs  = useTo ? 2'b00 : rsIn;
  assign mAlu = useTo ? '0 : aluIn;
  assign mWd  = useTo ? '0 : wdIn;
  assign tRw  = rwIn & useTo;
  assign tMw  = mwIn & useTo;
  assign tRs  = useTo ? rsIn : 2'b00;
  assign tAlu = useTo ? aluIn : '0;
  assign tWd  = useTo ? wdIn : '0;

  assign busMain.mem_ack   = ackIn & ~useTo;
  assign busMain.mem_rdata = rdataIn;
  assign busTo.mem_ack     = ackIn & useTo;
  assign busTo.mem_rdata   = rdataIn;

  mem_access_ctrl #(.DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWriteM(mRw), .MemWriteM(mMw), .ResultSrcM(mRs),
    .ALUResultM(mAlu), .WriteDataM(mWd),
    .bus(busMain),
    .StallM(mStall), .mem_err(mErr),
    .RegWriteW(mRwW), .ResultSrcW(mRsW), .ALUResultW(mAluW), .ReadDataW(mRdW)
  );

  mem_access_ctrl #(.DW(DW), .TIMEOUT(4)) dutTo (
    .clk(clk), .reset_n(reset_n),
    .RegWriteM(tRw), .MemWriteM(tMw), .ResultSrcM(tRs),
    .ALUResultM(tAlu), .WriteDataM(tWd),
    .bus(busTo),
    .StallM(tStall), .mem_err(tErr),
    .RegWriteW(tRwW), .ResultSrcW(tRsW), .ALUResultW(tAluW), .ReadDataW(tRdW)
  );

  assign sStall = useTo ? tStall : mStall;
  assign sErr   = useTo ? tErr : mErr;
  assign sReq   = useTo ? busTo.mem_req : busMain.mem_req;
  assign sWe    = useTo ? busTo.mem_we : busMain.mem_we;
  assign sAddr  = useTo ? busTo.mem_addr : busMain.mem_addr;
  assign sWdata = useTo ? busTo.mem_wdata : busMain.mem_wdata;
  assign sRw    = useTo ? tRwW : mRwW;
  assign sRs    = useTo ? tRsW : mRsW;
  assign sAlu   = useTo ? tAluW : mAluW;
  assign sRd    = useTo ? tRdW : mRdW;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastReqCyc = -1;
  int lastGap = -1;
  wbT sbQ[$];
  vecT tbl[8];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one MEM-stage instruction and follows it until it leaves MEM.
  task automatic applyStimulus(input vecT v);
    int  stallCycles = 0;
    int  reqCycles = 0;
    int  errCycles = 0;
    bit  done = 0;
    bit  wasStall;
    wbT  exp;
    wbT  got;
    useTo   = v.useTo;
    rwIn    = v.rw;
    mwIn    = v.mw;
    rsIn    = v.rs;
    aluIn   = v.alu;
    wdIn    = v.wd;
    rdataIn = v.rdata;
    ackIn   = 1'b0;
    exp.rw  = v.rw;
    exp.rs  = v.rs;
    exp.alu = v.alu;
    exp.rd  = v.expRd;
    sbQ.push_back(exp);
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      wasStall = sStall;
      if (sErr) errCycles++;
      if (sReq) begin
        checkOutput({v.name, ".addr"}, sAddr, v.alu);
        checkOutput({v.name, ".we"}, 32'(sWe), 32'(v.mw));
        checkOutput({v.name, ".wdata"}, sWdata, v.wd);
        if (reqCycles == 0 && lastReqCyc >= 0) lastGap = cyc - lastReqCyc - 1;
        lastReqCyc = cyc;
        ackIn = (reqCycles == v.ackWait);
        reqCycles++;
      end
      if (wasStall) stallCycles++;
      @(posedge clk);
      cyc++;
      #1;
      ackIn = 1'b0;
      if (wasStall) begin
        checkOutput({v.name, ".bubble"}, 32'(sRw), 32'd0);
      end else begin
        done = 1;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL %s.scoreboard: got empty queue, expected one entry", v.name);
        end else begin
          got = sbQ.pop_front();
          checkOutput({v.name, ".RegWriteW"}, 32'(sRw), 32'(got.rw));
          checkOutput({v.name, ".ResultSrcW"}, 32'(sRs), 32'(got.rs));
          checkOutput({v.name, ".ALUResultW"}, sAlu, got.alu);
          checkOutput({v.name, ".ReadDataW"}, sRd, got.rd);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.complete: got no completion, expected one within 400 cycles", v.name);
    end
    checkOutput({v.name, ".stallCycles"}, 32'(stallCycles), 32'(v.expStall));
    checkOutput({v.name, ".reqCycles"}, 32'(reqCycles), 32'(v.expReq));
    checkOutput({v.name, ".errCycles"}, 32'(errCycles), 32'(v.expErr));
    checkOutput({v.name, ".reqAfter"}, 32'(sReq), 32'd0);
    checkOutput({v.name, ".errAfter"}, 32'(sErr), 32'd0);
  endtask

  task automatic driveIdle();
    rwIn = 1'b0; mwIn = 1'b0; rsIn = 2'b00;
    aluIn = '0; wdIn = '0; rdataIn = '0; ackIn = 1'b0;
  endtask

  initial begin
    vecT v;
    //           name       useTo rw mw rs     alu           wd            rdata         wait stall req err expRd
    tbl[0] = '{"nonAccess", 1'b0, 1, 0, 2'b00, 32'h10,       32'h0,        32'h0,        0,   0,    0,  0,  32'h0};
    tbl[1] = '{"load0Wait", 1'b0, 1, 0, 2'b01, 32'h100,      32'h0,        32'hDEADBEEF, 0,   2,    1,  0,  32'hDEADBEEF};
    tbl[2] = '{"store4Wait",1'b0, 0, 1, 2'b00, 32'h200,      32'h55,       32'hAAAA5555, 4,   6,    5,  0,  32'h0};
    tbl[3] = '{"aluOp",     1'b0, 1, 0, 2'b10, 32'h1234,     32'h99,       32'h0,        0,   0,    0,  0,  32'h0};
    tbl[4] = '{"load2Wait", 1'b0, 1, 0, 2'b01, 32'h44,       32'h0,        32'h12345678, 2,   4,    3,  0,  32'h12345678};
    tbl[5] = '{"toLoadOk",  1'b1, 1, 0, 2'b01, 32'h300,      32'h0,        32'hCAFEF00D, 0,   2,    1,  0,  32'hCAFEF00D};
    tbl[6] = '{"toTimeout", 1'b1, 1, 0, 2'b01, 32'h304,      32'h0,        32'hFFFFFFFF, -1,  5,    4,  1,  32'h0};
    tbl[7] = '{"toResume",  1'b1, 1, 0, 2'b00, 32'h8,        32'h0,        32'h0,        0,   0,    0,  0,  32'h0};

    useTo = 1'b0;
    driveIdle();
    reset_n = 1'b0;
    #12;
    checkOutput("reset.mem_req", 32'(busMain.mem_req), 32'd0);
    checkOutput("reset.mem_we", 32'(busMain.mem_we), 32'd0);
    checkOutput("reset.mem_addr", busMain.mem_addr, 32'd0);
    checkOutput("reset.mem_wdata", busMain.mem_wdata, 32'd0);
    checkOutput("reset.mem_err", 32'(mErr), 32'd0);
    checkOutput("reset.RegWriteW", 32'(mRwW), 32'd0);
    checkOutput("reset.ResultSrcW", 32'(mRsW), 32'd0);
    checkOutput("reset.ALUResultW", mAluW, 32'd0);
    checkOutput("reset.ReadDataW", mRdW, 32'd0);
    checkOutput("reset.toReq", 32'(busTo.mem_req), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);
    useTo = 1'b0;
    driveIdle();

    // Ack outside BUSY must not start or finish anything.
    rwIn = 1'b1; aluIn = 32'h77; rdataIn = 32'h0BAD0BAD; ackIn = 1'b1;
    #1;
    checkOutput("strayAck.stall", 32'(sStall), 32'd0);
    @(posedge clk);
    #1;
    ackIn = 1'b0;
    checkOutput("strayAck.req", 32'(sReq), 32'd0);
    checkOutput("strayAck.ALUResultW", sAlu, 32'h77);
    checkOutput("strayAck.ReadDataW", sRd, 32'd0);

    // Asynchronous reset in the middle of a BUSY access.
    driveIdle();
    rwIn = 1'b1; rsIn = 2'b01; aluIn = 32'h500;
    @(posedge clk);
    #1;
    checkOutput("midReset.reqBefore", 32'(sReq), 32'd1);
    checkOutput("midReset.addrBefore", sAddr, 32'h500);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.req", 32'(sReq), 32'd0);
    checkOutput("midReset.addr", sAddr, 32'd0);
    checkOutput("midReset.RegWriteW", 32'(sRw), 32'd0);
    checkOutput("midReset.ALUResultW", sAlu, 32'd0);
    checkOutput("midReset.ReadDataW", sRd, 32'd0);
    driveIdle();
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    v = tbl[1];
    v.name = "afterReset"; v.alu = 32'h600; v.rdata = 32'h600DF00D; v.expRd = 32'h600DF00D;
    applyStimulus(v);

    // Two back-to-back zero-wait loads.
    lastReqCyc = -1;
    lastGap = -1;
    v = tbl[1];
    v.name = "b2bFirst"; v.alu = 32'h700; v.rdata = 32'h11112222; v.expRd = 32'h11112222;
    applyStimulus(v);
    v.name = "b2bSecond"; v.alu = 32'h704; v.rdata = 32'h33334444; v.expRd = 32'h33334444;
    applyStimulus(v);
    checkOutput("b2b.reqGap", 32'(lastGap), 32'd2);

    driveIdle();
    checkOutput("scoreboard.empty", 32'(sbQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
